// File: rtl/modo_treino_pkg.sv
// =====================================================================
// Module  : modo_treino_pkg
// Brief   : State encodings and error codes shared by the trainer FSM.
// Revision: 1.0
// =====================================================================
`default_nettype none

package modo_treino_pkg;

   localparam logic [3:0] c_OCIOSO         = 4'd0;
   localparam logic [3:0] c_INICIA         = 4'd1;
   localparam logic [3:0] c_MOSTRA         = 4'd2;
   localparam logic [3:0] c_ESPERA_MOSTRA  = 4'd3;
   localparam logic [3:0] c_ESPERA_NOTA    = 4'd4;
   localparam logic [3:0] c_TOCA           = 4'd5;
   localparam logic [3:0] c_COMPARA        = 4'd6;
   localparam logic [3:0] c_PROXIMA_RODADA = 4'd7;
   localparam logic [3:0] c_ERRO           = 4'd8;
   localparam logic [3:0] c_AGUARDA_TENTAR = 4'd9;
   localparam logic [3:0] c_GANHOU         = 4'd10;
   localparam logic [3:0] c_PERDEU         = 4'd11;

   // Error code: bit 0 = wrong note, bit 1 = timing / timeout
   localparam logic [1:0] c_ERRO_NENHUM = 2'b00;
   localparam logic [1:0] c_ERRO_NOTA   = 2'b01;
   localparam logic [1:0] c_ERRO_TEMPO  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/contador_batidas.sv
// =====================================================================
// Module  : contador_batidas
// Brief   : Beat counter for the player timeout; saturates at the limit.
// Revision: 1.0
// =====================================================================
`default_nettype none

module contador_batidas #(
   parameter int TIMEOUT_BEATS = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic habilita,
   input  logic tick_batida,
   output logic fim
);

   localparam logic [7:0] c_LIMITE = 8'(TIMEOUT_BEATS);

   logic [7:0] r_contagem;

   always_ff @(posedge clock) begin
      if (reset || limpa) begin
         r_contagem <= 8'd0;
      end else if (habilita && tick_batida && (r_contagem != c_LIMITE)) begin
         r_contagem <= r_contagem + 8'd1;
      end
   end

   assign fim = (r_contagem == c_LIMITE);

endmodule

`default_nettype wire

// File: rtl/modo_treino_controlador.sv
// =====================================================================
// Module  : modo_treino_controlador
// Brief   : Follow-the-melody trainer control unit with lives, beat
//           timeout, score and direct song-memory addressing.
// Revision: 1.0
// =====================================================================
`default_nettype none

module modo_treino_controlador
   import modo_treino_pkg::*;
#(
   parameter int ADDR_W        = 5,
   parameter int TIMEOUT_BEATS = 8,
   parameter int VIDAS         = 3,
   parameter int LIFE_W        = 2,
   parameter int SCORE_W       = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               nota_feita,
   input  logic               nota_correta,
   input  logic               tempo_correto,
   input  logic               tick_batida,
   input  logic               fim_musica,
   input  logic               tentar,
   output logic [ADDR_W-1:0]  endereco,
   output logic [ADDR_W-1:0]  rodada,
   output logic [LIFE_W-1:0]  vidas,
   output logic [SCORE_W-1:0] pontos,
   output logic               leds_mem,
   output logic               toca,
   output logic               vez_jogador,
   output logic               erro_nota,
   output logic               erro_tempo,
   output logic               ganhou,
   output logic               perdeu,
   output logic [3:0]         db_estado
);

   localparam logic [LIFE_W-1:0]  c_VIDAS_INI  = LIFE_W'(VIDAS);
   localparam logic [LIFE_W-1:0]  c_UM_VIDA    = LIFE_W'(1);
   localparam logic [ADDR_W-1:0]  c_UM_END     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]  c_RODADA_MAX = {ADDR_W{1'b1}};
   localparam logic [SCORE_W-1:0] c_UM_PONTO   = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] c_PONTOS_MAX = {SCORE_W{1'b1}};

   logic [3:0]         r_estado;
   logic [3:0]         w_prox;
   logic [ADDR_W-1:0]  r_endereco;
   logic [ADDR_W-1:0]  r_rodada;
   logic [LIFE_W-1:0]  r_vidas;
   logic [SCORE_W-1:0] r_pontos;
   logic [1:0]         r_erro;
   logic               r_leds_mem;
   logic               r_toca;
   logic               r_vez;
   logic               r_ganhou;
   logic               r_perdeu;

   logic w_fim_tempo;
   logic w_limpa_batidas;
   logic w_conta_batidas;
   logic w_ultima_nota;
   logic w_rodada_max;
   logic w_acertou;

   assign w_ultima_nota   = (r_endereco == r_rodada);
   assign w_rodada_max    = (r_rodada == c_RODADA_MAX);
   assign w_acertou       = nota_correta && tempo_correto;
   assign w_conta_batidas = (r_estado == c_ESPERA_NOTA);
   // The timeout window restarts every time the player is handed a new note
   assign w_limpa_batidas = (w_prox == c_ESPERA_NOTA) && (r_estado != c_ESPERA_NOTA);

   contador_batidas #(
      .TIMEOUT_BEATS (TIMEOUT_BEATS)
   ) u_contador_batidas (
      .clock       (clock),
      .reset       (reset),
      .limpa       (w_limpa_batidas),
      .habilita    (w_conta_batidas),
      .tick_batida (tick_batida),
      .fim         (w_fim_tempo)
   );

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         c_OCIOSO:         if (iniciar) w_prox = c_INICIA;
         c_INICIA:         w_prox = c_MOSTRA;
         c_MOSTRA:         w_prox = c_ESPERA_MOSTRA;
         c_ESPERA_MOSTRA:  if (tick_batida && w_ultima_nota) w_prox = c_ESPERA_NOTA;
         c_ESPERA_NOTA: begin
            if (nota_feita)       w_prox = c_TOCA;
            else if (w_fim_tempo) w_prox = c_ERRO;
         end
         c_TOCA:           if (!nota_feita) w_prox = c_COMPARA;
         c_COMPARA: begin
            if (!w_acertou)                    w_prox = c_ERRO;
            else if (!w_ultima_nota)           w_prox = c_ESPERA_NOTA;
            else if (fim_musica || w_rodada_max) w_prox = c_GANHOU;
            else                               w_prox = c_PROXIMA_RODADA;
         end
         c_PROXIMA_RODADA: w_prox = c_MOSTRA;
         c_ERRO:           w_prox = (r_vidas <= c_UM_VIDA) ? c_PERDEU : c_AGUARDA_TENTAR;
         c_AGUARDA_TENTAR: if (tentar) w_prox = c_MOSTRA;
         c_GANHOU,
         c_PERDEU:         if (iniciar) w_prox = c_INICIA;
         default:          w_prox = c_OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= c_OCIOSO;
         r_endereco <= '0;
         r_rodada   <= '0;
         r_vidas    <= '0;
         r_pontos   <= '0;
         r_erro     <= c_ERRO_NENHUM;
         r_leds_mem <= 1'b0;
         r_toca     <= 1'b0;
         r_vez      <= 1'b0;
         r_ganhou   <= 1'b0;
         r_perdeu   <= 1'b0;
      end else begin
         r_estado   <= w_prox;
         r_leds_mem <= (w_prox == c_ESPERA_MOSTRA);
         r_toca     <= (w_prox == c_ESPERA_MOSTRA) || (w_prox == c_TOCA);
         r_vez      <= (w_prox == c_ESPERA_NOTA);
         r_ganhou   <= (w_prox == c_GANHOU);
         r_perdeu   <= (w_prox == c_PERDEU);

         case (r_estado)
            c_ESPERA_MOSTRA: begin
               if (tick_batida) r_endereco <= w_ultima_nota ? '0 : r_endereco + c_UM_END;
            end
            c_COMPARA: begin
               if (w_acertou) begin
                  if (r_pontos != c_PONTOS_MAX) r_pontos <= r_pontos + c_UM_PONTO;
                  if (!w_ultima_nota) r_endereco <= r_endereco + c_UM_END;
               end
            end
            c_PROXIMA_RODADA: r_rodada <= r_rodada + c_UM_END;
            c_ERRO:           r_vidas  <= (r_vidas != '0) ? r_vidas - c_UM_VIDA : '0;
            default: ;
         endcase

         // Game setup and replay take effect on entry so the new values are visible there
         if (w_prox == c_INICIA) begin
            r_rodada <= '0;
            r_vidas  <= c_VIDAS_INI;
            r_pontos <= '0;
         end
         if ((w_prox == c_INICIA) || (w_prox == c_MOSTRA)) begin
            r_endereco <= '0;
            r_erro     <= c_ERRO_NENHUM;
         end else if (w_prox == c_ERRO) begin
            r_erro <= ((r_estado == c_COMPARA) && !nota_correta) ? c_ERRO_NOTA : c_ERRO_TEMPO;
         end
      end
   end

   assign endereco    = r_endereco;
   assign rodada      = r_rodada;
   assign vidas       = r_vidas;
   assign pontos      = r_pontos;
   assign leds_mem    = r_leds_mem;
   assign toca        = r_toca;
   assign vez_jogador = r_vez;
   assign erro_nota   = r_erro[0];
   assign erro_tempo  = r_erro[1];
   assign ganhou      = r_ganhou;
   assign perdeu      = r_perdeu;
   assign db_estado   = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_modo_treino_controlador.sv
// =====================================================================
// Module  : tb_modo_treino_controlador
// Brief   : Self-checking bench: vector table, corner sequences and
//           randomized games against a lives/score reference model.
// Revision: 1.0
// =====================================================================
`default_nettype none

module tb_modo_treino_controlador;
   import modo_treino_pkg::*;

   logic clock = 1'b0;
   logic reset, iniciar, nota_feita, nota_correta, tempo_correto, tick_batida, tentar;
   logic fim_en;
   logic [4:0] ultimo;
   logic fim_musica;

   logic [4:0] endereco_a, rodada_a;
   logic [1:0] vidas_a;
   logic [7:0] pontos_a;
   logic       leds_a, toca_a, vez_a, en_a, et_a, ganhou_a, perdeu_a;
   logic [3:0] est_a;

   logic [1:0] endereco_b, rodada_b, vidas_b, pontos_b;
   logic       leds_b, toca_b, vez_b, en_b, et_b, ganhou_b, perdeu_b;
   logic [3:0] est_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // Song ROM stand-in: end-of-song flag at address 'ultimo'
   assign fim_musica = fim_en && (endereco_a == ultimo);

   modo_treino_controlador dut_a (
      .clock(clock), .reset(reset), .iniciar(iniciar), .nota_feita(nota_feita),
      .nota_correta(nota_correta), .tempo_correto(tempo_correto), .tick_batida(tick_batida),
      .fim_musica(fim_musica), .tentar(tentar), .endereco(endereco_a), .rodada(rodada_a),
      .vidas(vidas_a), .pontos(pontos_a), .leds_mem(leds_a), .toca(toca_a),
      .vez_jogador(vez_a), .erro_nota(en_a), .erro_tempo(et_a), .ganhou(ganhou_a),
      .perdeu(perdeu_a), .db_estado(est_a)
   );

   modo_treino_controlador #(.ADDR_W(2), .SCORE_W(2)) dut_b (
      .clock(clock), .reset(reset), .iniciar(iniciar), .nota_feita(nota_feita),
      .nota_correta(nota_correta), .tempo_correto(tempo_correto), .tick_batida(tick_batida),
      .fim_musica(1'b0), .tentar(tentar), .endereco(endereco_b), .rodada(rodada_b),
      .vidas(vidas_b), .pontos(pontos_b), .leds_mem(leds_b), .toca(toca_b),
      .vez_jogador(vez_b), .erro_nota(en_b), .erro_tempo(et_b), .ganhou(ganhou_b),
      .perdeu(perdeu_b), .db_estado(est_b)
   );

   typedef struct packed {
      bit         aperta;
      bit         nc;
      bit         tc;
      logic [3:0] est;
      bit         en;
      bit         et;
      int         vidas;
      int         pontos;
   } vetor_t;

   vetor_t tabela [5];

   task automatic chk(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
      end
   endtask

   function automatic logic [3:0] est(input int d);
      return (d == 0) ? est_a : est_b;
   endfunction

   function automatic logic vez(input int d);
      return (d == 0) ? vez_a : vez_b;
   endfunction

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1; iniciar = 1'b0; nota_feita = 1'b0; nota_correta = 1'b0;
      tempo_correto = 1'b0; tick_batida = 1'b0; tentar = 1'b0;
      ciclo();
      ciclo();
      reset = 1'b0;
   endtask

   task automatic iniciar_jogo();
      iniciar = 1'b1;
      ciclo();
      iniciar = 1'b0;
   endtask

   task automatic wait_est(input int d, input logic [3:0] e, input int max, input string nome);
      for (int i = 0; i < max && est(d) != e; i++) ciclo();
      chk(nome, int'(est(d)), int'(e));
   endtask

   // Beat until the player is handed the round
   task automatic mostrar(input int d);
      for (int i = 0; i < 100 && !vez(d); i++) begin
         tick_batida = 1'b1;
         ciclo();
         tick_batida = 1'b0;
         ciclo();
      end
      chk("mostrar_vez", int'(vez(d)), 1);
   endtask

   // Press, hold, release with the given verdict; ends one cycle after COMPARA
   task automatic nota(input bit nc, input bit tc);
      nota_feita = 1'b1;
      ciclo();
      ciclo();
      nota_feita = 1'b0; nota_correta = nc; tempo_correto = tc;
      ciclo();
      ciclo();
      nota_correta = 1'b0; tempo_correto = 1'b0;
   endtask

   task automatic batidas(input int n);
      for (int i = 0; i < n; i++) begin
         tick_batida = 1'b1;
         ciclo();
         tick_batida = 1'b0;
         ciclo();
      end
   endtask

   task automatic chk_zero(input string nome);
      chk(nome, int'({endereco_a, rodada_a, vidas_a, pontos_a, leds_a, toca_a, vez_a,
                      en_a, et_a, ganhou_a, perdeu_a, est_a}), 0);
   endtask

   initial begin
      fim_en = 1'b1;
      ultimo = 5'd0;
      reset_dut();

      // Reset state
      chk_zero("reset_a");
      chk("reset_b", int'({endereco_b, rodada_b, vidas_b, pontos_b, leds_b, toca_b, vez_b,
                           en_b, et_b, ganhou_b, perdeu_b, est_b}), 0);

      // Start sequence and show-phase hold
      ultimo = 5'd2;
      iniciar_jogo();
      chk("inicia_est", int'(est_a), int'(c_INICIA));
      chk("inicia_vidas", int'(vidas_a), 3);
      chk("inicia_pontos", int'(pontos_a), 0);
      ciclo();
      chk("mostra_est", int'(est_a), int'(c_MOSTRA));
      ciclo();
      chk("espera_mostra_est", int'(est_a), int'(c_ESPERA_MOSTRA));
      ciclo(); ciclo(); ciclo();
      chk("espera_mostra_leds", int'(leds_a), 1);
      chk("espera_mostra_toca", int'(toca_a), 1);
      chk("espera_mostra_end", int'(endereco_a), 0);

      // Three perfect rounds, song ends at address 2
      for (int r = 0; r <= 2; r++) begin
         mostrar(0);
         for (int n = 0; n <= r; n++) nota(1'b1, 1'b1);
         if (r < 2) begin
            chk("proxima_est", int'(est_a), int'(c_PROXIMA_RODADA));
            ciclo();
            chk("rodada_inc", int'(rodada_a), r + 1);
         end
      end
      chk("ganhou_flag", int'(ganhou_a), 1);
      chk("ganhou_pontos", int'(pontos_a), 6);
      chk("ganhou_rodada", int'(rodada_a), 2);
      ciclo();
      chk("ganhou_hold", int'(est_a), int'(c_GANHOU));
      iniciar_jogo();
      chk("reinicia_est", int'(est_a), int'(c_INICIA));
      chk("reinicia_pontos", int'(pontos_a), 0);

      // Single-note outcome table from round 0 of a one-note song
      tabela[0] = '{1'b1, 1'b1, 1'b1, c_GANHOU,         1'b0, 1'b0, 3, 1};
      tabela[1] = '{1'b1, 1'b0, 1'b1, c_AGUARDA_TENTAR, 1'b1, 1'b0, 2, 0};
      tabela[2] = '{1'b1, 1'b1, 1'b0, c_AGUARDA_TENTAR, 1'b0, 1'b1, 2, 0};
      tabela[3] = '{1'b1, 1'b0, 1'b0, c_AGUARDA_TENTAR, 1'b1, 1'b0, 2, 0};
      tabela[4] = '{1'b0, 1'b0, 1'b0, c_AGUARDA_TENTAR, 1'b0, 1'b1, 2, 0};
      for (int v = 0; v < 5; v++) begin
         reset_dut();
         ultimo = 5'd0;
         iniciar_jogo();
         mostrar(0);
         if (tabela[v].aperta) nota(tabela[v].nc, tabela[v].tc);
         else batidas(8);
         wait_est(0, tabela[v].est, 20, $sformatf("tab%0d_est", v));
         chk($sformatf("tab%0d_erro_nota", v), int'(en_a), int'(tabela[v].en));
         chk($sformatf("tab%0d_erro_tempo", v), int'(et_a), int'(tabela[v].et));
         chk($sformatf("tab%0d_vidas", v), int'(vidas_a), tabela[v].vidas);
         chk($sformatf("tab%0d_pontos", v), int'(pontos_a), tabela[v].pontos);
      end

      // Wrong second note of round 1, then retry
      reset_dut();
      ultimo = 5'd4;
      iniciar_jogo();
      mostrar(0);
      nota(1'b1, 1'b1);
      ciclo();
      mostrar(0);
      nota(1'b1, 1'b1);
      chk("r1_nota0_est", int'(est_a), int'(c_ESPERA_NOTA));
      nota(1'b0, 1'b1);
      chk("r1_erro_est", int'(est_a), int'(c_ERRO));
      ciclo();
      chk("r1_aguarda_est", int'(est_a), int'(c_AGUARDA_TENTAR));
      chk("r1_erro_nota", int'(en_a), 1);
      chk("r1_vidas", int'(vidas_a), 2);
      ciclo(); ciclo();
      chk("r1_erro_sticky", int'(en_a), 1);
      tentar = 1'b1;
      ciclo();
      tentar = 1'b0;
      chk("r1_tentar_est", int'(est_a), int'(c_MOSTRA));
      chk("r1_tentar_rodada", int'(rodada_a), 1);
      chk("r1_tentar_erro", int'(en_a), 0);
      chk("r1_tentar_pontos", int'(pontos_a), 2);

      // Timeout after eight silent beats
      reset_dut();
      iniciar_jogo();
      mostrar(0);
      batidas(7);
      chk("to_7_est", int'(est_a), int'(c_ESPERA_NOTA));
      chk("to_7_erro", int'(et_a), 0);
      batidas(1);
      chk("to_8_est", int'(est_a), int'(c_ERRO));
      chk("to_8_erro", int'(et_a), 1);

      // Press together with the 8th beat wins over the timeout
      reset_dut();
      iniciar_jogo();
      mostrar(0);
      batidas(7);
      tick_batida = 1'b1; nota_feita = 1'b1;
      ciclo();
      tick_batida = 1'b0;
      chk("to_press_est", int'(est_a), int'(c_TOCA));
      chk("to_press_erro", int'(et_a), 0);
      nota_feita = 1'b0;

      // Press while the expired count is still pending also wins
      reset_dut();
      iniciar_jogo();
      mostrar(0);
      batidas(8 - 1);
      tick_batida = 1'b1;
      ciclo();
      tick_batida = 1'b0; nota_feita = 1'b1;
      ciclo();
      chk("to_late_press_est", int'(est_a), int'(c_TOCA));
      chk("to_late_press_erro", int'(et_a), 0);
      nota_feita = 1'b0;

      // Three errors lose the game; tentar ignored, iniciar restarts
      reset_dut();
      iniciar_jogo();
      for (int k = 0; k < 3; k++) begin
         mostrar(0);
         nota(1'b0, 1'b1);
         ciclo();
         chk($sformatf("perde_vidas%0d", k), int'(vidas_a), 2 - k);
         if (k < 2) begin
            tentar = 1'b1;
            ciclo();
            tentar = 1'b0;
         end
      end
      chk("perdeu_flag", int'(perdeu_a), 1);
      chk("perdeu_est", int'(est_a), int'(c_PERDEU));
      tentar = 1'b1;
      ciclo(); ciclo();
      tentar = 1'b0;
      chk("perdeu_tentar", int'(est_a), int'(c_PERDEU));
      iniciar_jogo();
      chk("perdeu_reinicia", int'(est_a), int'(c_INICIA));
      chk("perdeu_vidas", int'(vidas_a), 3);

      // Narrow instance: no round wrap, saturating score
      reset_dut();
      fim_en = 1'b0;
      iniciar_jogo();
      for (int r = 0; r <= 3; r++) begin
         mostrar(1);
         for (int n = 0; n <= r; n++) nota(1'b1, 1'b1);
         if (r < 3) begin
            chk("b_proxima_est", int'(est_b), int'(c_PROXIMA_RODADA));
            ciclo();
            chk("b_rodada", int'(rodada_b), r + 1);
         end
         chk("b_pontos", int'(pontos_b), ((r + 1) * (r + 2) / 2 > 3) ? 3 : (r + 1) * (r + 2) / 2);
      end
      chk("b_ganhou", int'(ganhou_b), 1);
      chk("b_ganhou_est", int'(est_b), int'(c_GANHOU));
      chk("b_rodada_final", int'(rodada_b), 3);
      fim_en = 1'b1;

      // Reset asserted in TOCA
      reset_dut();
      ultimo = 5'd4;
      iniciar_jogo();
      mostrar(0);
      nota(1'b1, 1'b1);
      ciclo();
      mostrar(0);
      nota_feita = 1'b1;
      ciclo();
      chk("toca_est", int'(est_a), int'(c_TOCA));
      chk("toca_out", int'(toca_a), 1);
      reset = 1'b1;
      ciclo();
      chk_zero("reset_em_toca");
      reset = 1'b0; nota_feita = 1'b0;

      // Randomized games against a lives/score/round model
      for (int g = 0; g < 6; g++) begin
         int  m_vidas, m_pontos, m_rodada, rodadas;
         bit  fim_jogo, falhou, m_en;
         reset_dut();
         ultimo   = 5'($urandom_range(0, 4));
         m_vidas  = 3; m_pontos = 0; m_rodada = 0;
         fim_jogo = 1'b0;
         rodadas  = 0;
         iniciar_jogo();
         while (!fim_jogo && rodadas < 40) begin
            rodadas++;
            mostrar(0);
            falhou = 1'b0;
            m_en   = 1'b0;
            for (int n = 0; n <= m_rodada && !falhou; n++) begin
               int sorte;
               sorte = int'($urandom_range(0, 9));
               if (sorte == 0) begin
                  nota(1'b0, 1'($urandom_range(0, 1)));
                  falhou = 1'b1; m_en = 1'b1;
               end else if (sorte == 1) begin
                  nota(1'b1, 1'b0);
                  falhou = 1'b1;
               end else if (sorte == 2) begin
                  batidas(8);
                  falhou = 1'b1;
               end else begin
                  nota(1'b1, 1'b1);
                  if (m_pontos < 255) m_pontos++;
               end
            end
            if (falhou) begin
               chk("rnd_erro_nota", int'(en_a), int'(m_en));
               chk("rnd_erro_tempo", int'(et_a), int'(!m_en));
               m_vidas--;
               ciclo();
               chk("rnd_vidas", int'(vidas_a), m_vidas);
               chk("rnd_pontos", int'(pontos_a), m_pontos);
               if (m_vidas == 0) begin
                  chk("rnd_perdeu", int'(perdeu_a), 1);
                  fim_jogo = 1'b1;
               end else begin
                  chk("rnd_aguarda", int'(est_a), int'(c_AGUARDA_TENTAR));
                  tentar = 1'b1;
                  ciclo();
                  tentar = 1'b0;
                  chk("rnd_replay_rodada", int'(rodada_a), m_rodada);
               end
            end else if (m_rodada == int'(ultimo)) begin
               chk("rnd_ganhou", int'(ganhou_a), 1);
               chk("rnd_ganhou_pontos", int'(pontos_a), m_pontos);
               chk("rnd_ganhou_rodada", int'(rodada_a), m_rodada);
               fim_jogo = 1'b1;
            end else begin
               m_rodada++;
               ciclo();
               chk("rnd_rodada", int'(rodada_a), m_rodada);
               chk("rnd_vidas_ok", int'(vidas_a), m_vidas);
            end
         end
         chk("rnd_jogo_terminou", int'(fim_jogo), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
